// File: rtl/alu_pkg.sv
// Shared definitions for seq_alu: opcode map, FSM state encoding and the
// single-cycle datapath, evaluated at a fixed maximum width and truncated by the caller.
package alu_pkg;

    localparam int MAX_W = 64;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_EQ   = 4'd10;
    localparam logic [3:0] OP_GT   = 4'd11;
    localparam logic [3:0] OP_LT   = 4'd12;
    localparam logic [3:0] OP_NE   = 4'd13;
    localparam logic [3:0] OP_BSET = 4'd14;
    localparam logic [3:0] OP_BCLR = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    typedef struct packed {
        logic [MAX_W-1:0] result;
        logic             carry;
        logic             negative;
        logic             overflow;
        logic             zero;
    } alu_res_t;

    // Operands arrive zero-extended to MAX_W; width marks where the real MSB sits.
    function automatic alu_res_t single_op(input logic [3:0]       op,
                                           input logic [MAX_W-1:0] a,
                                           input logic [MAX_W-1:0] b,
                                           input int unsigned      width);
        logic [MAX_W:0]   sum;
        logic [MAX_W-1:0] bit_mask;
        logic             in_range;
        alu_res_t         r;
        r        = '0;
        sum      = {1'b0, a} + {1'b0, b};
        in_range = b < MAX_W'(width);
        bit_mask = MAX_W'(1) << b;
        case (op)
            OP_ADD: begin
                r.result = sum[MAX_W-1:0];
                r.carry  = (sum >> width) != '0;
            end
            OP_SUB: begin
                r.result   = a - b;
                r.negative = b > a;
            end
            OP_AND:  r.result = a & b;
            OP_OR:   r.result = a | b;
            OP_XOR:  r.result = a ^ b;
            OP_NOT:  r.result = ~a;
            OP_SHR: begin
                r.result = a >> 1;
                r.carry  = a[0];
            end
            OP_SHL: begin
                r.result = a << 1;
                r.carry  = (a >> (width - 1)) != '0;
            end
            OP_EQ:   r.result = MAX_W'(a == b);
            OP_GT:   r.result = MAX_W'(a > b);
            OP_LT:   r.result = MAX_W'(a < b);
            OP_NE:   r.result = MAX_W'(a != b);
            OP_BSET: r.result = in_range ? (a | bit_mask) : a;
            OP_BCLR: r.result = in_range ? (a & ~bit_mask) : a;
            OP_DIV: begin
                // Only reached for b == 0; a nonzero divisor goes to the iterative unit.
                r.result = '1;
                r.zero   = 1'b1;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle, MSB first.
// done is combinational on the last iteration so the caller can load the result on that edge.
module seq_muldiv #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_quot,
    output logic             overflow
);

    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH:0]     trial, diff;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        is_div_d = is_div_q;
        // Division: acc upper half is the partial remainder, lower half the quotient.
        trial    = {acc_q[2*WIDTH-1:WIDTH], a_q[cnt_q]};
        diff     = trial - {1'b0, b_q};
        if (start) begin
            a_d      = a;
            b_d      = b;
            acc_d    = '0;
            cnt_d    = CNTW'(WIDTH - 1);
            busy_d   = 1'b1;
            is_div_d = is_div;
        end else if (busy_q) begin
            if (is_div_q) begin
                if (!diff[WIDTH]) begin
                    acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = {acc_q[2*WIDTH-2:0], 1'b0}
                      + (b_q[cnt_q] ? {{WIDTH{1'b0}}, a_q} : '0);
            end
            cnt_d = cnt_q - CNTW'(1);
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
        // NOTE: operand and accumulator registers carry no reset; they are reloaded
        // on every start and nothing observes them while busy_q is low.
        a_q      <= a_d;
        b_q      <= b_d;
        acc_q    <= acc_d;
        is_div_q <= is_div_d;
    end

    assign busy      = busy_q;
    assign done      = busy_q && (cnt_q == '0);
    assign prod_quot = acc_d[WIDTH-1:0];
    assign overflow  = |acc_d[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Registered 16-op ALU with valid/ready on both sides; mul/div are delegated to
// seq_muldiv, everything else completes on the accepting edge.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             negative,
    output logic             overflow,
    output logic             zero
);

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d, negative_q, negative_d;
    logic             overflow_q, overflow_d, zero_q, zero_d;
    logic             accept, md_start, md_busy, md_done, md_ovf;
    logic [WIDTH-1:0] md_res;
    alu_res_t         sc;

    seq_muldiv #(.WIDTH(WIDTH), .CNTW(IDXW)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .start     (md_start),
        .is_div    (op == OP_DIV),
        .a         (a),
        .b         (b),
        .busy      (md_busy),
        .done      (md_done),
        .prod_quot (md_res),
        .overflow  (md_ovf)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        carry_d     = carry_q;
        negative_d  = negative_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        sc          = single_op(op, MAX_W'(a), MAX_W'(b), WIDTH);
        in_ready    = (state_q == IDLE) && !md_busy && (!out_valid_q || out_ready);
        accept      = in_valid && in_ready;
        md_start    = accept && ((op == OP_MUL) || ((op == OP_DIV) && (b != '0)));
        case (state_q)
            IDLE: begin
                if (md_start) begin
                    state_d = (op == OP_MUL) ? MUL : DIV;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = sc.result[WIDTH-1:0];
                    carry_d     = sc.carry;
                    negative_d  = sc.negative;
                    overflow_d  = sc.overflow;
                    zero_d      = sc.zero;
                end
            end
            MUL, DIV: begin
                if (md_done) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    result_d    = md_res;
                    carry_d     = 1'b0;
                    negative_d  = 1'b0;
                    overflow_d  = (state_q == MUL) && md_ovf;
                    zero_d      = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            negative_q  <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            negative_q  <= negative_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign negative  = negative_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=8 and WIDTH=16: a transaction-level model predicts
// handshake and results every cycle; directed cases pin the model to hand-computed values.
module tb_seq_alu;

    typedef struct packed {
        logic [15:0] res;
        logic        c;
        logic        n;
        logic        o;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid_s, out_ready_s;
    logic [3:0]  op_s [2];
    logic [15:0] a_s [2];
    logic [15:0] b_s [2];
    logic [1:0]  in_ready_w, out_valid_w, carry_w, negative_w, overflow_w, zero_w;
    logic [7:0]  res8;
    logic [15:0] res16;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic chk_en   = 1'b0;

    logic m_valid [2];
    logic m_busy [2];
    logic m_chk_all [2];
    int   m_left [2];
    exp_t m_out [2];
    exp_t m_pend [2];

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]),
        .a(a_s[0][7:0]), .b(b_s[0][7:0]), .op(op_s[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready_s[0]),
        .result(res8), .carry(carry_w[0]), .negative(negative_w[0]),
        .overflow(overflow_w[0]), .zero(zero_w[0])
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]),
        .a(a_s[1]), .b(b_s[1]), .op(op_s[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready_s[1]),
        .result(res16), .carry(carry_w[1]), .negative(negative_w[1]),
        .overflow(overflow_w[1]), .zero(zero_w[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int wid(input int d);
        return (d == 1) ? 16 : 8;
    endfunction

    function automatic logic [15:0] dut_res(input int d);
        return (d == 1) ? res16 : {8'h00, res8};
    endfunction

    // Reference arithmetic straight from the opcode definitions.
    function automatic exp_t ref_op(input int w, input logic [3:0] op,
                                    input longint unsigned a, input longint unsigned b);
        longint unsigned mk;
        longint unsigned full;
        exp_t e;
        mk = (64'd1 << w) - 64'd1;
        e  = '0;
        case (op)
            4'd0: begin full = a + b; e.res = 16'(full & mk); e.c = (full >> w) != 0; end
            4'd1: begin e.res = 16'((a - b) & mk); e.n = b > a; end
            4'd2: begin full = a * b; e.res = 16'(full & mk); e.o = (full >> w) != 0; end
            4'd3: begin
                if (b == 0) begin e.res = 16'(mk); e.z = 1'b1; end
                else e.res = 16'(a / b);
            end
            4'd4: e.res = 16'(a & b);
            4'd5: e.res = 16'(a | b);
            4'd6: e.res = 16'(a ^ b);
            4'd7: e.res = 16'(~a & mk);
            4'd8: begin e.res = 16'(a >> 1); e.c = a[0]; end
            4'd9: begin e.res = 16'((a << 1) & mk); e.c = ((a >> (w - 1)) & 1) != 0; end
            4'd10: e.res = 16'(a == b);
            4'd11: e.res = 16'(a > b);
            4'd12: e.res = 16'(a < b);
            4'd13: e.res = 16'(a != b);
            4'd14: e.res = (b < 64'(w)) ? 16'(a | (64'd1 << b)) : 16'(a);
            default: e.res = (b < 64'(w)) ? 16'(a & ~(64'd1 << b) & mk) : 16'(a);
        endcase
        return e;
    endfunction

    task automatic model_step();
        exp_t e;
        logic rdy;
        longint unsigned mk, av, bv;
        for (int d = 0; d < 2; d++) begin
            mk = (64'd1 << wid(d)) - 64'd1;
            av = 64'(a_s[d]) & mk;
            bv = 64'(b_s[d]) & mk;
            if (rst) begin
                m_valid[d]   = 1'b0;
                m_busy[d]    = 1'b0;
                m_out[d]     = '0;
                m_chk_all[d] = 1'b1;
            end else begin
                rdy = !m_busy[d] && (!m_valid[d] || out_ready_s[d]);
                if (m_valid[d] && out_ready_s[d]) m_valid[d] = 1'b0;
                if (m_busy[d]) begin
                    m_left[d]--;
                    if (m_left[d] == 0) begin
                        m_busy[d]    = 1'b0;
                        m_valid[d]   = 1'b1;
                        m_out[d]     = m_pend[d];
                        m_chk_all[d] = 1'b0;
                    end
                end else if (in_valid_s[d] && rdy) begin
                    e = ref_op(wid(d), op_s[d], av, bv);
                    if (op_s[d] == 4'd2 || (op_s[d] == 4'd3 && bv != 0)) begin
                        m_busy[d] = 1'b1;
                        m_left[d] = wid(d);
                        m_pend[d] = e;
                    end else begin
                        m_valid[d]   = 1'b1;
                        m_out[d]     = e;
                        m_chk_all[d] = 1'b0;
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("in_ready[%0d]", d), 32'(in_ready_w[d]),
                      32'(!m_busy[d] && (!m_valid[d] || out_ready_s[d])));
                check($sformatf("out_valid[%0d]", d), 32'(out_valid_w[d]), 32'(m_valid[d]));
                if (m_valid[d] || m_chk_all[d]) begin
                    check($sformatf("result[%0d]", d), 32'(dut_res(d)), 32'(m_out[d].res));
                    check($sformatf("carry[%0d]", d), 32'(carry_w[d]), 32'(m_out[d].c));
                    check($sformatf("negative[%0d]", d), 32'(negative_w[d]), 32'(m_out[d].n));
                    check($sformatf("overflow[%0d]", d), 32'(overflow_w[d]), 32'(m_out[d].o));
                    check($sformatf("zero[%0d]", d), 32'(zero_w[d]), 32'(m_out[d].z));
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // Present an op, wait for acceptance and for the result; lat counts the accept edge as 1.
    task automatic issue(input int d, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, output int lat, output int low_rdy);
        int n;
        @(posedge clk);
        #2;
        in_valid_s[d] = 1'b1;
        op_s[d] = op;
        a_s[d]  = a;
        b_s[d]  = b;
        n = 0;
        @(negedge clk);
        while (!in_ready_w[d] && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("accept_wait", 32'(in_ready_w[d]), 32'd1);
        @(posedge clk);
        #2;
        in_valid_s[d] = 1'b0;
        lat = 1;
        low_rdy = 0;
        @(negedge clk);
        while (!out_valid_w[d] && lat < 50) begin
            if (!in_ready_w[d]) low_rdy++;
            lat++;
            @(negedge clk);
        end
        check("result_wait", 32'(out_valid_w[d]), 32'd1);
    endtask

    task automatic expect_out(input string name, input int d, input logic [15:0] res,
                              input logic c, input logic n, input logic o, input logic z);
        check({name, ".result"}, 32'(dut_res(d)), 32'(res));
        check({name, ".carry"}, 32'(carry_w[d]), 32'(c));
        check({name, ".negative"}, 32'(negative_w[d]), 32'(n));
        check({name, ".overflow"}, 32'(overflow_w[d]), 32'(o));
        check({name, ".zero"}, 32'(zero_w[d]), 32'(z));
    endtask

    initial begin
        int lat, low;
        exp_t pin;
        rst         = 1'b1;
        in_valid_s  = 2'b00;
        out_ready_s = 2'b11;
        for (int d = 0; d < 2; d++) begin
            op_s[d] = 4'd0;
            a_s[d]  = '0;
            b_s[d]  = '0;
        end
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset.out_valid", 32'(out_valid_w), 32'd0);
        check("reset.in_ready", 32'(in_ready_w), 32'd3);
        expect_out("reset", 0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        pin = ref_op(8, 4'd2, 64'd50, 64'd10);
        check("model.mul8", 32'({pin.res, pin.o}), 32'({16'd244, 1'b1}));
        pin = ref_op(8, 4'd15, 64'h10, 64'd9);
        check("model.bclr_oob", 32'(pin.res), 32'h10);

        issue(0, 4'd0, 16'd20, 16'd10, lat, low);
        check("add.lat", 32'(lat), 32'd1);
        expect_out("add", 0, 16'd30, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(0, 4'd0, 16'd250, 16'd10, lat, low);
        expect_out("add_carry", 0, 16'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(0, 4'd1, 16'd5, 16'd10, lat, low);
        expect_out("sub", 0, 16'd251, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(0, 4'd8, 16'h81, 16'd0, lat, low);
        expect_out("shr", 0, 16'd64, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(0, 4'd9, 16'h81, 16'd0, lat, low);
        expect_out("shl", 0, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(0, 4'd2, 16'd50, 16'd10, lat, low);
        check("mul.lat", 32'(lat), 32'd9);
        check("mul.in_ready_low", 32'(low), 32'd8);
        expect_out("mul", 0, 16'd244, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(0, 4'd3, 16'd50, 16'd10, lat, low);
        check("div.lat", 32'(lat), 32'd9);
        expect_out("div", 0, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(0, 4'd3, 16'd50, 16'd0, lat, low);
        check("div0.lat", 32'(lat), 32'd1);
        expect_out("div0", 0, 16'd255, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(0, 4'd14, 16'h10, 16'd3, lat, low);
        expect_out("bset", 0, 16'h18, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(0, 4'd14, 16'h10, 16'd9, lat, low);
        expect_out("bset_oob", 0, 16'h10, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(0, 4'd15, 16'hFF, 16'd7, lat, low);
        expect_out("bclr", 0, 16'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1, 4'd2, 16'd300, 16'd300, lat, low);
        check("mul16.lat", 32'(lat), 32'd17);
        expect_out("mul16", 1, 16'd24464, 1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure: first result held while a second op waits.
        @(posedge clk);
        #2;
        out_ready_s[0] = 1'b0;
        in_valid_s[0]  = 1'b1;
        op_s[0] = 4'd0;
        a_s[0]  = 16'd1;
        b_s[0]  = 16'd2;
        @(posedge clk);
        #2;
        op_s[0] = 4'd1;
        a_s[0]  = 16'd9;
        b_s[0]  = 16'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp.out_valid", 32'(out_valid_w[0]), 32'd1);
            check("bp.in_ready", 32'(in_ready_w[0]), 32'd0);
            check("bp.result", 32'(res8), 32'd3);
            @(posedge clk);
            #2;
        end
        out_ready_s[0] = 1'b1;
        @(negedge clk);
        check("bp.release_ready", 32'(in_ready_w[0]), 32'd1);
        @(posedge clk);
        #2;
        in_valid_s[0] = 1'b0;
        @(negedge clk);
        check("bp.second_valid", 32'(out_valid_w[0]), 32'd1);
        check("bp.second_result", 32'(res8), 32'd5);

        // Reset in the fourth DIV cycle discards the operation.
        @(posedge clk);
        #2;
        in_valid_s[0] = 1'b1;
        op_s[0] = 4'd3;
        a_s[0]  = 16'd50;
        b_s[0]  = 16'd10;
        @(posedge clk);
        #2;
        in_valid_s[0] = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        @(negedge clk);
        check("rst_mid.busy", 32'(in_ready_w[0]), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid.out_valid", 32'(out_valid_w[0]), 32'd0);
        check("rst_mid.in_ready", 32'(in_ready_w[0]), 32'd1);
        expect_out("rst_mid", 0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        check("rst_mid.no_late_result", 32'(out_valid_w[0]), 32'd0);

        // Randomized traffic on both widths; the compare process does the checking.
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #2;
            rst = ($urandom_range(0, 199) == 0);
            for (int d = 0; d < 2; d++) begin
                logic [15:0] mk;
                mk = (d == 1) ? 16'hFFFF : 16'h00FF;
                in_valid_s[d]  = ($urandom_range(0, 3) != 0);
                out_ready_s[d] = ($urandom_range(0, 3) != 0);
                op_s[d] = 4'($urandom_range(0, 15));
                a_s[d]  = 16'($urandom) & mk;
                case ($urandom_range(0, 3))
                    0: b_s[d] = 16'd0;
                    1: b_s[d] = 16'($urandom_range(0, wid(d) + 3));
                    default: b_s[d] = 16'($urandom) & mk;
                endcase
            end
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        in_valid_s  = 2'b00;
        out_ready_s = 2'b11;
        repeat (25) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
